// File: rtl/switch_rr_scheduler.sv
// rtl/switch_rr_scheduler.sv - round-robin drain scheduler for switch port FIFOs
// Optional multi-word grants are compiled in with SW_SCHED_BURST_EN.
module switch_rr_scheduler #(
  parameter int NUM_OF_PORTS = 4,
  parameter int WORD_WIDTH   = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sched_en,
  input  logic [NUM_OF_PORTS-1:0]            port_ready,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
  output logic [NUM_OF_PORTS-1:0]            port_read,
  output logic [WORD_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_OF_PORTS)-1:0]    out_port,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int PW = $clog2(NUM_OF_PORTS);

  typedef enum logic [1:0] {IDLE, REQ, CAPT, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] grant_next;
  logic [PW-1:0] sel;
  logic          any_ready;
  logic          burst_more;

  // Descending scan so the port closest above ptr is the last (winning) write.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = ptr;
    any_ready = 1'b0;
    for (int i = NUM_OF_PORTS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_OF_PORTS) idx = idx - NUM_OF_PORTS;
      if (port_ready[idx]) begin
        sel       = PW'(idx);
        any_ready = 1'b1;
      end
    end
  end

  assign grant_next = (int'(grant) == NUM_OF_PORTS - 1) ? '0 : grant + 1'b1;

  always_comb begin
    port_read = '0;
    if (!rst && state == REQ && port_ready[grant]) port_read[grant] = 1'b1;
  end

  assign busy = (state != IDLE);

`ifdef SW_SCHED_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt;

  // burst_cnt already includes the word being handed off in HOLD.
  assign burst_more = sched_en && port_ready[grant] && (int'(burst_cnt) < MAX_BURST);
`else
  assign burst_more = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      out_data  <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
`ifdef SW_SCHED_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sched_en && any_ready) begin
            grant <= sel;
            state <= REQ;
`ifdef SW_SCHED_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (port_ready[grant]) begin
            state <= CAPT;
          end else begin
            ptr   <= grant_next;
            state <= IDLE;
          end
        end
        CAPT: begin
          out_data  <= port_out[int'(grant)*WORD_WIDTH +: WORD_WIDTH];
          out_port  <= grant;
          out_valid <= 1'b1;
          state     <= HOLD;
`ifdef SW_SCHED_BURST_EN
          burst_cnt <= burst_cnt + 1'b1;
`endif
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (burst_more) begin
              state <= REQ;
            end else begin
              ptr   <= grant_next;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_rr_scheduler.sv
// tb/tb_switch_rr_scheduler.sv - directed vector bench for switch_rr_scheduler
module tb_switch_rr_scheduler;

  logic        clk;
  logic        rst;
  logic        sched_en;
  logic [3:0]  port_ready;
  logic [31:0] port_out;
  logic [3:0]  port_read;
  logic [7:0]  out_data;
  logic [1:0]  out_port;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  switch_rr_scheduler #(
    .NUM_OF_PORTS(4),
    .WORD_WIDTH  (8),
    .MAX_BURST   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sched_en  (sched_en),
    .port_ready(port_ready),
    .port_out  (port_out),
    .port_read (port_read),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] pr;
    logic       ordy;
    logic [3:0] e_read;
    logic       e_busy;
    logic       e_valid;
    logic [1:0] e_port;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic en, input logic [3:0] pr,
                              input logic ordy, input logic [3:0] e_read, input logic e_busy,
                              input logic e_valid, input logic [1:0] e_port, input logic [7:0] e_data);
    vec_t v;
    v.rst = r; v.en = en; v.pr = pr; v.ordy = ordy;
    v.e_read = e_read; v.e_busy = e_busy; v.e_valid = e_valid;
    v.e_port = e_port; v.e_data = e_data;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [3:0] pr, input logic ordy);
    rst = r; sched_en = en; port_ready = pr; out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1; sched_en = 1'b1; port_ready = 4'hF; out_ready = 1'b1;
    port_out = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

`ifndef SW_SCHED_BURST_EN
    // reset, then four single-word rounds and a wrap back to port 0
    add(1, 1, 4'hF, 1, 4'h0, 0, 0, 0, 8'h00);
    add(1, 1, 4'hF, 1, 4'h0, 0, 0, 0, 8'h00);
    for (int p = 0; p < 5; p++) begin
      add(0, 1, 4'hF, 1, 4'h0, 0, 0, 0, 8'h00);
      add(0, 1, 4'hF, 1, 4'(1 << (p % 4)), 1, 0, 0, 8'h00);
      add(0, 1, 4'hF, 1, 4'h0, 1, 0, 0, 8'h00);
      add(0, 1, 4'hF, 1, 4'h0, 1, 1, 2'(p % 4), 8'hA0 + 8'(p % 4));
    end
    // backpressure on port 2
    add(0, 1, 4'h4, 0, 4'h0, 0, 0, 0, 8'h00);
    add(0, 1, 4'h4, 0, 4'h4, 1, 0, 0, 8'h00);
    add(0, 1, 4'h4, 0, 4'h0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) add(0, 1, 4'h4, 0, 4'h0, 1, 1, 2, 8'hA2);
    add(0, 1, 4'h4, 1, 4'h0, 1, 1, 2, 8'hA2);
    // port 1 granted then drops in REQ; next grant goes to port 2, not 0
    add(0, 1, 4'h2, 1, 4'h0, 0, 0, 0, 8'h00);
    add(0, 1, 4'h5, 1, 4'h0, 1, 0, 0, 8'h00);
    add(0, 1, 4'h5, 1, 4'h0, 0, 0, 0, 8'h00);
    add(0, 1, 4'h5, 1, 4'h4, 1, 0, 0, 8'h00);
    add(0, 1, 4'h5, 1, 4'h0, 1, 0, 0, 8'h00);
    add(0, 1, 4'h5, 1, 4'h0, 1, 1, 2, 8'hA2);
    // sched_en low blocks grants; re-enable resumes at port 3
    add(0, 0, 4'hF, 1, 4'h0, 0, 0, 0, 8'h00);
    add(0, 0, 4'hF, 1, 4'h0, 0, 0, 0, 8'h00);
    add(0, 1, 4'hF, 1, 4'h0, 0, 0, 0, 8'h00);
    add(0, 1, 4'hF, 1, 4'h8, 1, 0, 0, 8'h00);
    add(0, 1, 4'hF, 1, 4'h0, 1, 0, 0, 8'h00);
    add(0, 1, 4'hF, 1, 4'h0, 1, 1, 3, 8'hA3);
    add(0, 1, 4'h0, 1, 4'h0, 0, 0, 0, 8'h00);

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].en, vecs[i].pr, vecs[i].ordy);
      #1;
      check("port_read", i, 32'(port_read), 32'(vecs[i].e_read));
      check("busy", i, 32'(busy), 32'(vecs[i].e_busy));
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check("out_port", i, 32'(out_port), 32'(vecs[i].e_port));
        check("out_data", i, 32'(out_data), 32'(vecs[i].e_data));
      end
    end
`else
    @(posedge clk);
    @(negedge clk);
`endif

    // reset while a word sits in HOLD
    @(negedge clk); drive(1, 1, 4'h0, 0);
    @(negedge clk); drive(0, 1, 4'h2, 0);
    @(negedge clk); #1; check("rh_read", 0, 32'(port_read), 32'h2);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("rh_valid", 0, 32'(out_valid), 32'h1);
    check("rh_port", 0, 32'(out_port), 32'h1);
    drive(1, 1, 4'h2, 0);
    @(negedge clk); #1;
    check("rh_valid", 1, 32'(out_valid), 32'h0);
    check("rh_busy", 1, 32'(busy), 32'h0);
    check("rh_read", 1, 32'(port_read), 32'h0);
    drive(0, 1, 4'hF, 1);
    #1; check("rh_read", 2, 32'(port_read), 32'h0);
    @(negedge clk); #1;
    check("rh_read", 3, 32'(port_read), 32'h1);

`ifdef SW_SCHED_BURST_EN
    begin
      int cnt0, cnt3, nrec, cyc;
      logic [1:0] exp_seq [7];
      logic [1:0] got_seq [7];
      exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
      cnt0 = 6; cnt3 = 1; nrec = 0; cyc = 0;
      @(negedge clk); drive(1, 1, 4'h0, 1);
      @(negedge clk);
      while (nrec < 7 && cyc < 80) begin
        drive(0, 1, {cnt3 > 0, 2'b00, cnt0 > 0}, 1);
        #1;
        if (out_valid && out_ready) begin
          got_seq[nrec] = out_port;
          nrec++;
        end
        if (port_read[0]) cnt0--;
        if (port_read[3]) cnt3--;
        cyc++;
        @(negedge clk);
      end
      check("burst_count", 0, 32'(nrec), 32'd7);
      for (int k = 0; k < nrec; k++) check("burst_port", k, 32'(got_seq[k]), 32'(exp_seq[k]));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
